// File: rtl/irq_68k_if.sv
// 68000 bus signals as seen by the interrupt controller.
// The CPU-side model drives them (master); irq_68k only samples them (slave).
interface irq_68k_if;
    logic [23:1] M68K_ADDR;
    logic [2:0]  M68K_DATA;
    logic        M68K_RW;
    logic        nAS;
    logic        nLDS;
    logic        CLK_EN_68K_P;

    modport master (
        output M68K_ADDR, M68K_DATA, M68K_RW, nAS, nLDS, CLK_EN_68K_P
    );

    modport slave (
        input  M68K_ADDR, M68K_DATA, M68K_RW, nAS, nLDS, CLK_EN_68K_P
    );
endinterface

// File: rtl/irq_68k.sv
// Interrupt request controller for the 68000 core.
// Three pending flags are held: VBL (level 1), timer (level 2) and cold boot (level 3).
// The highest pending level is driven onto the active-low IPL lines from a register.
// Software clears flags by writing to REG_IRQACK ($3C000C and its mirrors).
module irq_68k (
    input  logic       CLK,
    input  logic       nRESET,
    irq_68k_if.slave   bus,
    input  logic       VBL_IRQ,
    input  logic       TIMER_IRQ,
    output logic       IPL2,
    output logic       IPL1,
    output logic       IPL0,
    output logic [2:0] IRQ_PENDING
);

    localparam logic [2:0] IPL_LVL3 = 3'b100;
    localparam logic [2:0] IPL_LVL2 = 3'b101;
    localparam logic [2:0] IPL_LVL1 = 3'b110;
    localparam logic [2:0] IPL_NONE = 3'b111;

    // Event edge detection
    logic       r_vbl_d;
    logic       r_tmr_d;
    logic       r_vbl_rise;
    logic       r_tmr_rise;

    // Acknowledge decode
    logic       r_acksel_d;
    logic       r_ack;
    logic [2:0] r_ack_data;
    logic       w_acksel;
    logic       w_ack_now;

    // Pending flags and encoded level
    logic [2:0] r_pend;
    logic [2:0] w_set;
    logic [2:0] w_clr;
    logic [2:0] w_ipl_next;
    logic [2:0] r_ipl;

    // Interrupt-acknowledge cycles are decoded only to show they are
    // deliberately ignored: flags are cleared solely through REG_IRQACK.
    logic       w_unused_iack;
    assign w_unused_iack = ~bus.nAS & (&bus.M68K_ADDR[23:4]);

    // Write to $3C000C or any mirror: A23..A17 select the block, A3..A1 pick the register.
    assign w_acksel = (bus.M68K_ADDR[23:17] == 7'b0011110) &&
                      (bus.M68K_ADDR[3:1]   == 3'b110)     &&
                      !bus.nAS && !bus.nLDS && !bus.M68K_RW;

    // A held (wait-stated) write acks only on its first enabled sample.
    assign w_ack_now = bus.CLK_EN_68K_P & w_acksel & ~r_acksel_d;

    // Registering the rise keeps the set and the clear paths at the same latency.
    // NOTE: every clocked register uses non-blocking (<=) so all flops update
    // together from pre-edge values; blocking here would create ordering races.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_vbl_d    <= 1'b0;
            r_tmr_d    <= 1'b0;
            r_vbl_rise <= 1'b0;
            r_tmr_rise <= 1'b0;
        end else begin
            r_vbl_d    <= VBL_IRQ;
            r_tmr_d    <= TIMER_IRQ;
            r_vbl_rise <= VBL_IRQ & ~r_vbl_d;
            r_tmr_rise <= TIMER_IRQ & ~r_tmr_d;
        end
    end

    // Bus sampling on CPU phase-1 enables; the ack and its data are applied one clock later.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_acksel_d <= 1'b0;
            r_ack      <= 1'b0;
            r_ack_data <= 3'b000;
        end else begin
            if (bus.CLK_EN_68K_P) begin
                r_acksel_d <= w_acksel;
            end
            r_ack      <= w_ack_now;
            r_ack_data <= bus.M68K_DATA;
        end
    end

    // Data bit 0 clears level 3, bit 1 level 2, bit 2 level 1 (flag bits are ordered by level).
    assign w_set = {1'b0, r_tmr_rise, r_vbl_rise};
    assign w_clr = r_ack ? {r_ack_data[0], r_ack_data[1], r_ack_data[2]} : 3'b000;

    // Pending flags: cold boot starts pending; a simultaneous set beats a clear.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_pend <= 3'b100;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    // Priority encoder from pending flags to active-low IPL code.
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    always_comb begin
        w_ipl_next = IPL_NONE;
        if (r_pend[2]) begin
            w_ipl_next = IPL_LVL3;
        end else if (r_pend[1]) begin
            w_ipl_next = IPL_LVL2;
        end else if (r_pend[0]) begin
            w_ipl_next = IPL_LVL1;
        end
    end

    // Registered IPL so the CPU never sees an intermediate code between two levels.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_ipl <= IPL_NONE;
        end else begin
            r_ipl <= w_ipl_next;
        end
    end

    assign IPL2        = r_ipl[2];
    assign IPL1        = r_ipl[1];
    assign IPL0        = r_ipl[0];
    assign IRQ_PENDING = r_pend;

endmodule

// File: doc/irq_68k.md
# irq_68k

Interrupt request controller for the 68000 core. It latches the VBL and timer interrupt events plus the power-on cold-boot request as pending flags, and encodes the highest pending level onto the active-low IPL2..IPL0 inputs of the CPU wrapper. It also decodes software acknowledge writes to REG_IRQACK ($3C000C and its mirrors). It sits directly upstream of the CPU wrapper, samples the same bus signals that wrapper produces, and drives its IPL inputs.

## Interface
Parameters:
- none; the address decode and level map are fixed by the NeoGeo memory map.

Ports:
- CLK  in  1  system clock. Single clock domain.
- nRESET  in  1  reset. Asynchronous, active-low.
- CLK_EN_68K_P  in  1  CPU phase-1 enable. Bus inputs are sampled only on cycles where it is high.
- VBL_IRQ  in  1  vertical-blank event, synchronous to CLK. The rising edge sets pending level 1.
- TIMER_IRQ  in  1  display-position timer event, synchronous to CLK. The rising edge sets pending level 2.
- M68K_ADDR  in  23  CPU address [23:1].
- M68K_DATA  in  3  CPU write data bits [2:0].
- M68K_RW  in  1  high = read, low = write.
- nAS  in  1  address strobe, active-low.
- nLDS  in  1  lower data strobe, active-low.
- IPL2, IPL1, IPL0  out  1 each  encoded interrupt level, active-low (all high = no request).
- IRQ_PENDING  out  3  pending flags, [0]=level 1, [1]=level 2, [2]=level 3. For debug and verification.

## Operation
- Three pending flags:
  - P1: VBL, level 1.
  - P2: timer, level 2.
  - P3: cold boot, level 3.
- Reset (nRESET low, asynchronous):
  - P1=0, P2=0, P3=1.
  - Edge-detect registers = 0.
  - Write-strobe history = 0.
  - IPL2..0 = 3'b111.
  - IRQ_PENDING = 3'b100.
- Event edges:
  - VBL_IRQ is compared with its value on the previous CLK; a 0→1 transition sets P1.
  - TIMER_IRQ is handled the same way and sets P2.
  - Edges are detected on every CLK and do not depend on CLK_EN_68K_P.
  - An input held high sets its flag only once.
- Ack decode (ACKSEL):
  - Condition: M68K_ADDR[23:17]=7'b0011110, M68K_ADDR[3:1]=3'b110, nAS=0, nLDS=0, M68K_RW=0.
  - ACKSEL is sampled on CLK_EN_68K_P cycles only.
  - The ack fires once per bus cycle: on the first enabled sample where ACKSEL=1 and the previous enabled sample had ACKSEL=0.
- Ack action, using the data sampled on that same enable:
  - M68K_DATA[0] clears P3.
  - M68K_DATA[1] clears P2.
  - M68K_DATA[2] clears P1.
  - Bits written as zero leave their flags unchanged.
- Set and clear of the same flag in the same CLK: set wins, so the new event stays pending.
- Priority encoding:
  - P3 → level 3, IPL=3'b100.
  - else P2 → level 2, IPL=3'b101.
  - else P1 → level 1, IPL=3'b110.
  - else IPL=3'b111.
- IACK cycles (nAS low with M68K_ADDR[23:4] all ones) have no effect on the pending flags. Software must acknowledge through REG_IRQACK.
- Reads of REG_IRQACK are ignored.

## Timing
- Event latency:
  - Rising edge of VBL_IRQ or TIMER_IRQ at CLK n → flag set at edge n+1.
  - IPL updated at edge n+2, because the encoder output is registered.
- Ack latency:
  - Ack sampled at enable edge m → flag cleared at edge m+1.
  - IPL updated at edge m+2.
- IPL outputs are glitch-free registered values. They change at most once per CLK and never pass through an intermediate code between two valid levels.
- A write cycle held across many enables (wait states) acks exactly once. A back-to-back second write acks again only after ACKSEL has been sampled 0 at least once.
- Reset asserted mid-bus-cycle forces the reset values immediately. After release, no ack is taken until a new 0→1 ACKSEL transition.

## Test plan
- Reset release: after nRESET rises, IRQ_PENDING=3'b100 and IPL=3'b100 hold with no other stimulus. Write $0001 to $3C000C → IRQ_PENDING=3'b000 and IPL=3'b111 two clocks after the sampling enable.
- VBL only: VBL_IRQ pulses 0→1 and stays high for 100 clocks → P1 set once, IPL=3'b110 at edge n+2. Write data $0004 → IPL=3'b111. VBL_IRQ still high → P1 stays 0.
- Priority: P1 and P2 both pending → IPL=3'b101. Ack with $0002 → IPL=3'b110. Ack with $0004 → IPL=3'b111.
- Mirror and reject:
  - Write $0007 to $3DFFFC (mirror) → all flags clear.
  - Write to $3C000A, a read from $3C000C, or a write with nLDS=1 → flags unchanged.
- Simultaneous: TIMER_IRQ rising edge in the same CLK that an ack with $0002 applies → P2 remains 1 and IPL=3'b101.
- Wait-stated write: ack write with nAS held low for 20 enables, while TIMER_IRQ rises during the held cycle → exactly one clear before the edge. P2 is set after the edge and not cleared by the same held cycle.
